// File: rtl/ula_result_reader_if.sv
// Downstream byte-stream link between ula_result_reader and its consumer.
//   m_valid : beat available
//   m_ready : consumer accepts beat
//   m_data  : current beat (one half of a ULA result)
//   m_last  : beat is the upper half of a result
// Modports: master (driven by the reader), slave (the consumer side).
interface ula_result_reader_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/ula_result_reader.sv
// Buffers 2*DATA_WIDTH ULA results in a small FIFO and serializes each one
// downstream as two DATA_WIDTH beats, lower half first.
// Ports:
//   clk, rst     : single clock, synchronous active-high reset
//   ula_valid_i  : ULA result strobe (no back-pressure toward the ULA)
//   ula_data_i   : ULA result
//   m_if         : downstream stream (master modport of ula_result_reader_if)
//   ovf_o        : sticky, set when a result had to be dropped
//   count_o      : number of results currently stored
module ula_result_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ula_valid_i,
    input  logic [2*DATA_WIDTH-1:0]     ula_data_i,
    ula_result_reader_if.master         m_if,
    output logic                        ovf_o,
    output logic [$clog2(FIFO_DEPTH):0] count_o
);
    localparam int unsigned RW = 2 * DATA_WIDTH;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOW   = 2'd1,
        ST_HIGH  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [RW-1:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [CW-1:0]     count_nxt, count_after_pop;
    logic [RW-1:0]     head_nxt;
    logic              pop, lo_hs, full, push_ok;
    logic              m_valid_nxt, m_last_nxt;
    logic [DATA_WIDTH-1:0] m_data_nxt;

    // Handshake and accept decode; a HIGH-beat handshake frees the head slot.
    always_comb begin
        lo_hs   = (state == ST_LOW)  && m_if.m_ready;
        pop     = (state == ST_HIGH) && m_if.m_ready;
        full    = (count_o == CW'(FIFO_DEPTH));
        push_ok = ula_valid_i && (!full || pop);
    end

    // Occupancy, read pointer and the head word as they will be after this edge.
    always_comb begin
        count_nxt = count_o;
        if (push_ok && !pop) begin
            count_nxt = count_o + CW'(1);
        end else if (pop && !push_ok) begin
            count_nxt = count_o - CW'(1);
        end
        count_after_pop = count_o - CW'(pop);
        rd_ptr_nxt      = rd_ptr + PW'(pop);
        // When nothing survives the pop, the next head can only be the incoming result.
        head_nxt = (count_after_pop == '0) ? ula_data_i : mem[rd_ptr_nxt];
    end

    // FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (push_ok)     state_nxt = ST_LOW;
            ST_LOW:   if (lo_hs)       state_nxt = ST_HIGH;
            ST_HIGH:  if (pop)         state_nxt = (count_nxt != '0) ? ST_LOW : ST_EMPTY;
            default:                   state_nxt = ST_EMPTY;
        endcase
    end

    // FSM: output decode, evaluated for the next state so outputs can be registered.
    always_comb begin
        m_valid_nxt = 1'b0;
        m_last_nxt  = 1'b0;
        m_data_nxt  = '0;
        case (state_nxt)
            ST_LOW: begin
                m_valid_nxt = 1'b1;
                m_data_nxt  = head_nxt[DATA_WIDTH-1:0];
            end
            ST_HIGH: begin
                m_valid_nxt = 1'b1;
                m_last_nxt  = 1'b1;
                m_data_nxt  = head_nxt[RW-1:DATA_WIDTH];
            end
            default: ;
        endcase
    end

    // Result storage; contents are don't-care outside the live window, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= ula_data_i;
        end
    end

    // Pointers, occupancy, overflow flag and registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_o      <= '0;
            ovf_o        <= 1'b0;
            m_if.m_valid <= 1'b0;
            m_if.m_last  <= 1'b0;
            m_if.m_data  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (ula_valid_i && !push_ok) begin
                ovf_o <= 1'b1;
            end
            rd_ptr       <= rd_ptr_nxt;
            count_o      <= count_nxt;
            m_if.m_valid <= m_valid_nxt;
            m_if.m_last  <= m_last_nxt;
            m_if.m_data  <= m_data_nxt;
        end
    end
endmodule
